// File: rtl/ascon_serial_io_pkg.sv
// rtl/ascon_serial_io_pkg.sv - shared state, mode and beat-count definitions
package ascon_serial_io_pkg;

  // Controller phases: collect beats, kick the core, wait for it, drain results
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int NONCE_W = 128;
  localparam int TAG_W   = 128;

  // Widest field carried over the beat interface (nonce/tag are always 128)
  function automatic int max_width(input int k, input int l, input int y);
    int m;
    m = 128;
    if (k > m) m = k;
    if (l > m) m = l;
    if (y > m) m = y;
    return m;
  endfunction

  // Beats per transfer; every field uses the same count so they move in lockstep
  function automatic int beat_count(input int k, input int l, input int y, input int bw);
    return (max_width(k, l, y) + bw - 1) / bw;
  endfunction

endpackage

// File: rtl/ascon_beat_shifter.sv
// rtl/ascon_beat_shifter.sv - MSB-first beat shift register for one field
module ascon_beat_shifter #(
  parameter int F          = 128,
  parameter int BW         = 8,
  parameter int NB         = 16,
  parameter bit SERIAL_OUT = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_load,
  input  logic [F-1:0]                         i_load_data,
  input  logic                                 i_shift,
  input  logic [BW-1:0]                        i_beat,
  output logic [(SERIAL_OUT ? BW : F)-1:0]     o_data
);

  localparam int W  = NB * BW;
  localparam int OW = SERIAL_OUT ? BW : F;

  logic [W-1:0] r_data;

  // Parallel load left-aligns the field; shifting moves beats toward the MSB end,
  // so the first beat in ends up on top and trailing zeros pad short fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= W'(i_load_data) << (W - F);
    end else if (i_shift) begin
      r_data <= (r_data << BW) | W'(i_beat);
    end
  end

  // Deserialiser exposes the whole field, serialiser exposes the current top beat
  assign o_data = r_data[W-1 -: OW];

endmodule

// File: rtl/ascon_serial_io.sv
// rtl/ascon_serial_io.sv - beat-serial load/unload wrapper around a parallel Ascon core
module ascon_serial_io
  import ascon_serial_io_pkg::*;
#(
  parameter int K  = 128,
  parameter int L  = 40,
  parameter int Y  = 80,
  parameter int BW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_validxSI,
  output logic              in_readyxSO,
  input  logic              modexSI,
  input  logic [BW-1:0]     keyxSI,
  input  logic [BW-1:0]     noncexSI,
  input  logic [BW-1:0]     associated_dataxSI,
  input  logic [BW-1:0]     textxSI,
  input  logic [BW-1:0]     tag_inxSI,
  output logic [K-1:0]      key,
  output logic [NONCE_W-1:0] nonce,
  output logic [L-1:0]      associated_data,
  output logic [Y-1:0]      text,
  output logic              core_modexSO,
  output logic              core_startxSO,
  input  logic              core_donexSI,
  input  logic [Y-1:0]      core_textxSI,
  input  logic [TAG_W-1:0]  core_tagxSI,
  output logic              out_validxSO,
  input  logic              out_readyxSI,
  output logic [BW-1:0]     textxSO,
  output logic [BW-1:0]     tagxSO,
  output logic              tag_okxSO
);

  localparam int NB = beat_count(K, L, Y, BW);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic               r_mode;
  logic               r_tag_ok;
  logic               w_accept;
  logic               w_handover;
  logic               w_capture;
  logic               w_last;
  logic               w_release;
  logic [TAG_W-1:0]   w_tag_in;
  logic [BW-1:0]      w_text_beat;
  logic [BW-1:0]      w_tag_beat;

  assign w_accept   = in_validxSI & in_readyxSO;
  assign w_handover = out_validxSO & out_readyxSI;
  assign w_capture  = (r_state == ST_WAIT) & core_donexSI;
  assign w_last     = (r_cnt == LAST_BEAT);
  // Plaintext only leaves the block for encryption or a verified decryption
  assign w_release  = (r_mode == MODE_ENC) | r_tag_ok;

  assign core_modexSO = r_mode;
  assign tag_okxSO    = r_tag_ok;

  ascon_beat_shifter #(.F(K), .BW(BW), .NB(NB), .SERIAL_OUT(1'b0)) u_key_in (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_accept), .i_beat(keyxSI), .o_data(key)
  );

  ascon_beat_shifter #(.F(NONCE_W), .BW(BW), .NB(NB), .SERIAL_OUT(1'b0)) u_nonce_in (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_accept), .i_beat(noncexSI), .o_data(nonce)
  );

  ascon_beat_shifter #(.F(L), .BW(BW), .NB(NB), .SERIAL_OUT(1'b0)) u_ad_in (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_accept), .i_beat(associated_dataxSI), .o_data(associated_data)
  );

  ascon_beat_shifter #(.F(Y), .BW(BW), .NB(NB), .SERIAL_OUT(1'b0)) u_text_in (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_accept), .i_beat(textxSI), .o_data(text)
  );

  ascon_beat_shifter #(.F(TAG_W), .BW(BW), .NB(NB), .SERIAL_OUT(1'b0)) u_tag_in (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_accept), .i_beat(tag_inxSI), .o_data(w_tag_in)
  );

  ascon_beat_shifter #(.F(Y), .BW(BW), .NB(NB), .SERIAL_OUT(1'b1)) u_text_out (
    .clk(clk), .rst(rst), .i_load(w_capture), .i_load_data(core_textxSI),
    .i_shift(w_handover), .i_beat('0), .o_data(w_text_beat)
  );

  ascon_beat_shifter #(.F(TAG_W), .BW(BW), .NB(NB), .SERIAL_OUT(1'b1)) u_tag_out (
    .clk(clk), .rst(rst), .i_load(w_capture), .i_load_data(core_tagxSI),
    .i_shift(w_handover), .i_beat('0), .o_data(w_tag_beat)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD:   if (w_accept && w_last)   w_next_state = ST_START;
      ST_START:                            w_next_state = ST_WAIT;
      ST_WAIT:   if (core_donexSI)         w_next_state = ST_UNLOAD;
      ST_UNLOAD: if (w_handover && w_last) w_next_state = ST_LOAD;
      default:                             w_next_state = ST_LOAD;
    endcase
  end

  // Handshake and result outputs; everything held low while reset is asserted
  always_comb begin
    in_readyxSO   = 1'b0;
    core_startxSO = 1'b0;
    out_validxSO  = 1'b0;
    textxSO       = '0;
    tagxSO        = '0;
    if (!rst) begin
      case (r_state)
        ST_LOAD:  in_readyxSO   = 1'b1;
        ST_START: core_startxSO = 1'b1;
        ST_UNLOAD: begin
          out_validxSO = 1'b1;
          tagxSO       = w_tag_beat;
          textxSO      = w_release ? w_text_beat : '0;
        end
        default: ;
      endcase
    end
  end

  // Single beat counter shared by load and unload, which never overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept || w_handover) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Direction is latched with the first beat of a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_ENC;
    end else if (w_accept && (r_cnt == '0)) begin
      r_mode <= modexSI;
    end
  end

  // Verdict is fixed when the core reports done and held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_ok <= 1'b0;
    end else if (w_capture) begin
      r_tag_ok <= (r_mode == MODE_ENC) || (core_tagxSI == w_tag_in);
    end
  end

endmodule

// File: tb/tb_ascon_serial_io.sv
// tb/tb_ascon_serial_io.sv - directed scoreboard bench for ascon_serial_io
module tb_ascon_serial_io;

  localparam int NB = 16;

  localparam logic [127:0] KEY      = 128'h2db083053e848cefa30007336c47a5a1;
  localparam logic [127:0] NONCE    = 128'h3f3607dbce3503ba84f5843d623de056;
  localparam logic [39:0]  AD       = 40'h4153434f4e;
  localparam logic [79:0]  CT       = 80'h87a59a2ea49b233259e3;
  localparam logic [127:0] TAGIN    = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [79:0]  PT       = 80'h4153434f4e2d41454144;
  localparam logic [127:0] ENC_TAG  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, mode;
  logic [7:0]   key_b, nonce_b, ad_b, text_b, tag_b;
  logic [127:0] key_o, nonce_o;
  logic [39:0]  ad_o;
  logic [79:0]  text_o;
  logic         core_mode, core_start, core_done;
  logic [79:0]  core_text;
  logic [127:0] core_tag;
  logic         out_valid, out_ready;
  logic [7:0]   text_so, tag_so;
  logic         tag_ok;

  logic         in_valid32, in_ready32;
  logic [31:0]  key_b32;
  logic [127:0] key_o32, nonce_o32;
  logic [39:0]  ad_o32;
  logic [79:0]  text_o32;
  logic         core_mode32, core_start32, out_valid32, tag_ok32;
  logic [31:0]  text_so32, tag_so32;

  ascon_serial_io #(.K(128), .L(40), .Y(80), .BW(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_validxSI(in_valid), .in_readyxSO(in_ready), .modexSI(mode),
    .keyxSI(key_b), .noncexSI(nonce_b), .associated_dataxSI(ad_b),
    .textxSI(text_b), .tag_inxSI(tag_b),
    .key(key_o), .nonce(nonce_o), .associated_data(ad_o), .text(text_o),
    .core_modexSO(core_mode), .core_startxSO(core_start), .core_donexSI(core_done),
    .core_textxSI(core_text), .core_tagxSI(core_tag),
    .out_validxSO(out_valid), .out_readyxSI(out_ready),
    .textxSO(text_so), .tagxSO(tag_so), .tag_okxSO(tag_ok)
  );

  ascon_serial_io #(.K(128), .L(40), .Y(80), .BW(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_validxSI(in_valid32), .in_readyxSO(in_ready32), .modexSI(1'b0),
    .keyxSI(key_b32), .noncexSI(32'd0), .associated_dataxSI(32'd0),
    .textxSI(32'd0), .tag_inxSI(32'd0),
    .key(key_o32), .nonce(nonce_o32), .associated_data(ad_o32), .text(text_o32),
    .core_modexSO(core_mode32), .core_startxSO(core_start32), .core_donexSI(1'b0),
    .core_textxSI(80'd0), .core_tagxSI(128'd0),
    .out_validxSO(out_valid32), .out_readyxSI(1'b0),
    .textxSO(text_so32), .tagxSO(tag_so32), .tag_okxSO(tag_ok32)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q_text[$];
  logic [7:0] q_tag[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat i of a field: bits [width-1-i*bw -: bw], zero once past the field
  function automatic logic [31:0] field_beat(input logic [127:0] f, input int width,
                                             input int bw, input int i);
    logic [127:0] s;
    if (i * bw >= width) return 32'd0;
    s = f >> (width - bw * (i + 1));
    return s[31:0] & ((32'd1 << bw) - 32'd1);
  endfunction

  task automatic load8(input logic m, input logic [79:0] t, input bit gap, input string name);
    check({name, "_ready_at_start"}, in_ready, 1);
    for (int i = 0; i < NB; i++) begin
      mode    = (i == 0) ? m : ~m;
      key_b   = 8'(field_beat(KEY, 128, 8, i));
      nonce_b = 8'(field_beat(NONCE, 128, 8, i));
      ad_b    = (i * 8 >= 40) ? 8'($urandom) : 8'(field_beat(AD, 40, 8, i));
      text_b  = (i * 8 >= 80) ? 8'($urandom) : 8'(field_beat(t, 80, 8, i));
      tag_b   = 8'(field_beat(TAGIN, 128, 8, i));
      in_valid = 1'b1;
      tick();
      if (gap && i != NB - 1) begin
        in_valid = 1'b0;
        key_b = 8'($urandom); nonce_b = 8'($urandom); text_b = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b0;
    check({name, "_start_pulse"}, core_start, 1);
    check({name, "_ready_in_start"}, in_ready, 0);
    check({name, "_key"}, key_o, KEY);
    check({name, "_nonce"}, nonce_o, NONCE);
    check({name, "_ad"}, ad_o, AD);
    check({name, "_text"}, text_o, t);
    check({name, "_mode"}, core_mode, m);
    tick();
    check({name, "_start_drop"}, core_start, 0);
    check({name, "_ready_in_wait"}, in_ready, 0);
  endtask

  task automatic core_stub(input logic [79:0] ct, input logic [127:0] tg,
                           input logic exp_ok, input logic dec, input string name);
    for (int j = 0; j < NB; j++) begin
      q_text.push_back((dec && !exp_ok) ? 8'h00 : 8'(field_beat(ct, 80, 8, j)));
      q_tag.push_back(8'(field_beat(tg, 128, 8, j)));
    end
    core_text = ct;
    core_tag  = tg;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    core_text = '0;
    core_tag  = '0;
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_tag_ok"}, tag_ok, exp_ok);
  endtask

  task automatic unload(input int stall_at, input logic exp_ok, input string name);
    int handed = 0;
    int stall_left = 5;
    int budget = 200;
    while (handed < NB && budget > 0) begin
      if (handed == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        check({name, "_stall_valid"}, out_valid, 1);
        if (q_text.size() > 0) begin
          check({name, "_stall_text"}, text_so, q_text[0]);
          check({name, "_stall_tag"}, tag_so, q_tag[0]);
        end
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          if (q_text.size() == 0 || q_tag.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_extra_beat: observed beat %0d expected none", name, handed);
          end else begin
            check($sformatf("%s_text_beat%0d", name, handed), text_so, q_text.pop_front());
            check($sformatf("%s_tag_beat%0d", name, handed), tag_so, q_tag.pop_front());
          end
          check($sformatf("%s_tag_ok_beat%0d", name, handed), tag_ok, exp_ok);
          handed++;
        end
      end
      tick();
      budget--;
    end
    out_ready = 1'b0;
    check({name, "_handovers"}, handed, NB);
    check({name, "_valid_after"}, out_valid, 0);
    check({name, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; mode = 1'b0;
    key_b = '0; nonce_b = '0; ad_b = '0; text_b = '0; tag_b = '0;
    core_done = 1'b0; core_text = '0; core_tag = '0; out_ready = 1'b0;
    in_valid32 = 1'b0; key_b32 = '0;
    tick();
    tick();

    check("rst_in_ready", in_ready, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_textxSO", text_so, 0);
    check("rst_tagxSO", tag_so, 0);
    check("rst_tag_ok", tag_ok, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_key", key_o, 0);
    check("rst_in_ready32", in_ready32, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_in_ready32", in_ready32, 1);

    core_done = 1'b1;
    core_text = PT;
    tick();
    core_done = 1'b0;
    core_text = '0;
    check("done_in_load_valid", out_valid, 0);
    check("done_in_load_ready", in_ready, 1);

    load8(1'b0, CT, 1'b0, "enc");
    core_stub(PT, ENC_TAG, 1'b1, 1'b0, "enc");
    unload(-1, 1'b1, "enc");

    load8(1'b1, CT, 1'b0, "dec_bad");
    core_stub(PT, TAGIN ^ 128'd1, 1'b0, 1'b1, "dec_bad");
    unload(-1, 1'b0, "dec_bad");

    load8(1'b1, CT, 1'b1, "dec_gap");
    core_stub(PT, TAGIN, 1'b1, 1'b1, "dec_ok");
    unload(7, 1'b1, "dec_ok");

    load8(1'b1, CT, 1'b0, "rst_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_done = 1'b1;
    core_text = PT;
    core_tag  = TAGIN;
    tick();
    core_done = 1'b0;
    tick();
    check("rst_wait_out_valid", out_valid, 0);
    check("rst_wait_in_ready", in_ready, 1);
    check("rst_wait_key", key_o, 0);
    check("rst_wait_nonce", nonce_o, 0);
    check("rst_wait_ad", ad_o, 0);
    check("rst_wait_text", text_o, 0);
    check("rst_wait_tag_ok", tag_ok, 0);
    check("rst_wait_mode", core_mode, 0);

    for (int i = 0; i < 4; i++) begin
      key_b32 = field_beat(KEY, 128, 32, i);
      in_valid32 = 1'b1;
      tick();
    end
    in_valid32 = 1'b0;
    check("bw32_key_top", key_o32[127:96], 32'h2db08305);
    check("bw32_key", key_o32, KEY);
    check("bw32_start", core_start32, 1);
    check("bw32_ready", in_ready32, 0);
    check("bw32_nonce", nonce_o32, 0);
    check("bw32_ad", ad_o32, 0);
    check("bw32_text", text_o32, 0);
    check("bw32_mode", core_mode32, 0);
    check("bw32_out_valid", out_valid32, 0);
    check("bw32_textxSO", text_so32, 0);
    check("bw32_tagxSO", tag_so32, 0);
    check("bw32_tag_ok", tag_ok32, 0);
    tick();
    check("bw32_start_drop", core_start32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
